// File: rtl/avalon_pkg.sv
// Shared types and helpers for the Avalon-ST buffering blocks.
package avalon_pkg;

    typedef enum logic {
        MODE_CUT_THROUGH = 1'b0,
        MODE_STORE_FWD   = 1'b1
    } buffer_mode_e;

    // A pointer into a depth-entry ring; at least one bit so DEPTH=1-style corner widths stay legal.
    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST link: payload (data, empty, sop, eop) with vld/rdy handshake.
// A beat transfers on a rising clk edge where vld & rdy; once vld is high the
// master holds vld and payload stable until that transfer happens.
interface avalon_st_if #(
    parameter int DATA_WIDTH = 8,
    parameter int META_WIDTH = 2
);
    logic [DATA_WIDTH-1:0] data;
    logic [META_WIDTH-1:0] empty;
    logic                  sop;
    logic                  eop;
    logic                  vld;
    logic                  rdy;

    modport master (output data, empty, sop, eop, vld, input rdy);
    modport slave  (input data, empty, sop, eop, vld, output rdy);
endinterface

// File: rtl/avalon_stream_buffer_wrap_ctr.sv
// Ring pointer: counts 0..MAX-1 and wraps, with synchronous clear.
module avalon_stream_buffer_wrap_ctr
    import avalon_pkg::*;
#(
    parameter int  MAX = 4,
    localparam int W   = ptr_w(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == W'(MAX - 1)) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/avalon_stream_buffer.sv
// Avalon-ST elastic buffer: circular store of DEPTH beats, cut-through or
// store-and-forward release, synchronous flush, occupancy status.
module avalon_stream_buffer
    import avalon_pkg::*;
#(
    parameter int           DEPTH            = 4,
    parameter buffer_mode_e MODE             = MODE_CUT_THROUGH,
    parameter bit           SUPPRESS_WARNING = 1'b0,
    localparam int          PW               = ptr_w(DEPTH),
    localparam int          LW               = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    avalon_st_if.slave    msg_in,
    avalon_st_if.master   msg_out,
    output logic [LW-1:0] level,
    output logic [LW-1:0] pkt_count,
    output logic          full,
    output logic          empty
);

    localparam int DW = $bits(msg_in.data);
    localparam int MW = $bits(msg_in.empty);
    localparam int BW = DW + MW + 2;

    if ($bits(msg_in.data) != $bits(msg_out.data)) begin : g_dw_chk
        $fatal(1, "avalon_stream_buffer: msg_in/msg_out DATA_WIDTH differ");
    end
    if (DEPTH < 2 || DEPTH > 64) begin : g_depth_chk
        $fatal(1, "avalon_stream_buffer: DEPTH %0d outside 2..64", DEPTH);
    end
    if (DEPTH > 16 && !SUPPRESS_WARNING) begin : g_depth_warn
        $warning("avalon_stream_buffer: DEPTH %0d is large for a register store", DEPTH);
    end

    logic [BW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          release_ok;

    assign full       = (level == LW'(DEPTH));
    assign empty      = (level == '0);
    // rdy depends only on registered level and flush, never on msg_out.rdy.
    assign msg_in.rdy = ~full & ~flush;
    assign push       = msg_in.vld & msg_in.rdy;

    // The full override keeps packets longer than DEPTH moving in store-forward mode.
    assign release_ok = (MODE == MODE_CUT_THROUGH) ? 1'b1 : ((pkt_count != '0) | full);
    assign msg_out.vld = ~empty & release_ok & ~flush;
    assign pop         = msg_out.vld & msg_out.rdy;

    assign {msg_out.sop, msg_out.eop, msg_out.empty, msg_out.data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {msg_in.sop, msg_in.eop, msg_in.empty, msg_in.data};
        end
    end

    avalon_stream_buffer_wrap_ctr #(.MAX(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (push),
        .cnt   (wr_ptr)
    );

    avalon_stream_buffer_wrap_ctr #(.MAX(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (pop),
        .cnt   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            level     <= '0;
            pkt_count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            case ({push & msg_in.eop, pop & msg_out.eop})
                2'b10:   pkt_count <= pkt_count + LW'(1);
                2'b01:   pkt_count <= pkt_count - LW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_stream_buffer.sv
// Bench for avalon_stream_buffer: four configurations run side by side against a queue model.
module tb_avalon_stream_buffer;
    import avalon_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       in_vld   [N];
    logic [7:0] in_data  [N];
    logic [1:0] in_empty [N];
    logic       in_sop   [N];
    logic       in_eop   [N];
    logic       out_rdy  [N];
    logic       flush    [N];

    logic        in_rdy_a  [N];
    logic        out_vld_a [N];
    logic [11:0] out_beat  [N];
    logic [7:0]  level_a   [N];
    logic [7:0]  pkt_a     [N];
    logic        full_a    [N];
    logic        empty_a   [N];

    int total = 0;
    int bad   = 0;

    function automatic int dep_of(input int k);
        case (k)
            0:       return 4;
            1:       return 3;
            2:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic bit sf_of(input int k);
        return k >= 2;
    endfunction

    // Instances: 0 cut-through D4, 1 cut-through D3, 2 store-fwd D8, 3 store-fwd D4.
    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 8 : 4;
        localparam buffer_mode_e M = (g >= 2) ? MODE_STORE_FWD : MODE_CUT_THROUGH;
        localparam int LW = $clog2(D + 1);

        avalon_st_if #(.DATA_WIDTH(8), .META_WIDTH(2)) in_if ();
        avalon_st_if #(.DATA_WIDTH(8), .META_WIDTH(2)) out_if ();
        logic [LW-1:0] lvl;
        logic [LW-1:0] pc;
        logic          fl;
        logic          em;

        assign in_if.vld   = in_vld[g];
        assign in_if.data  = in_data[g];
        assign in_if.empty = in_empty[g];
        assign in_if.sop   = in_sop[g];
        assign in_if.eop   = in_eop[g];
        assign out_if.rdy  = out_rdy[g];

        assign in_rdy_a[g]  = in_if.rdy;
        assign out_vld_a[g] = out_if.vld;
        assign out_beat[g]  = {out_if.sop, out_if.eop, out_if.empty, out_if.data};
        assign level_a[g]   = 8'(lvl);
        assign pkt_a[g]     = 8'(pc);
        assign full_a[g]    = fl;
        assign empty_a[g]   = em;

        avalon_stream_buffer #(.DEPTH(D), .MODE(M), .SUPPRESS_WARNING(1'b0)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush[g]),
            .msg_in    (in_if),
            .msg_out   (out_if),
            .level     (lvl),
            .pkt_count (pc),
            .full      (fl),
            .empty     (em)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one queue of beats {sop,eop,empty,data} per instance.
    logic [11:0] exp_q [N][$];
    bit armed = 0;

    function automatic int eop_cnt(input int k);
        int n = 0;
        for (int i = 0; i < exp_q[k].size(); i++)
            if (exp_q[k][i][10]) n++;
        return n;
    endfunction

    function automatic bit exp_vld(input int k);
        if (flush[k] || exp_q[k].size() == 0) return 1'b0;
        if (!sf_of(k)) return 1'b1;
        return (exp_q[k].size() == dep_of(k)) || (eop_cnt(k) != 0);
    endfunction

    always @(posedge clk) begin
        bit v;
        bit p;
        if (!rst_n) begin
            armed = 1;
            for (int k = 0; k < N; k++) exp_q[k].delete();
        end else begin
            for (int k = 0; k < N; k++) begin
                if (flush[k]) begin
                    exp_q[k].delete();
                end else begin
                    v = exp_vld(k);
                    p = in_vld[k] && (exp_q[k].size() < dep_of(k));
                    if (v && out_rdy[k]) void'(exp_q[k].pop_front());
                    if (p) exp_q[k].push_back({in_sop[k], in_eop[k], in_empty[k], in_data[k]});
                end
            end
        end
    end

    bit track_max = 0;
    int max_lvl0  = 0;

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < N; k++) begin
                int sz;
                bit ev;
                sz = exp_q[k].size();
                ev = exp_vld(k);
                check($sformatf("i%0d_level", k), 32'(level_a[k]), 32'(sz));
                check($sformatf("i%0d_pkt", k), 32'(pkt_a[k]), 32'(eop_cnt(k)));
                check($sformatf("i%0d_full", k), 32'(full_a[k]), 32'(sz == dep_of(k)));
                check($sformatf("i%0d_empty", k), 32'(empty_a[k]), 32'(sz == 0));
                check($sformatf("i%0d_in_rdy", k), 32'(in_rdy_a[k]),
                      32'(sz != dep_of(k) && !flush[k]));
                check($sformatf("i%0d_out_vld", k), 32'(out_vld_a[k]), 32'(ev));
                if (ev) check($sformatf("i%0d_beat", k), 32'(out_beat[k]), 32'(exp_q[k][0]));
            end
            if (track_max && int'(level_a[0]) > max_lvl0) max_lvl0 = int'(level_a[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all(input logic rdy);
        for (int k = 0; k < N; k++) begin
            in_vld[k] = 1'b0;
            in_sop[k] = 1'b0;
            in_eop[k] = 1'b0;
            flush[k]  = 1'b0;
            out_rdy[k] = rdy;
        end
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic s, input logic e);
        for (int k = 0; k < N; k++) begin
            in_vld[k]   = 1'b1;
            in_data[k]  = d;
            in_empty[k] = d[1:0];
            in_sop[k]   = s;
            in_eop[k]   = e;
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            in_data[k]  = '0;
            in_empty[k] = '0;
        end
        idle_all(1'b1);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("rst_empty%0d", k), 32'(empty_a[k]), 32'd1);
            check($sformatf("rst_full%0d", k), 32'(full_a[k]), 32'd0);
            check($sformatf("rst_vld%0d", k), 32'(out_vld_a[k]), 32'd0);
            check($sformatf("rst_rdy%0d", k), 32'(in_rdy_a[k]), 32'd1);
        end

        // Back-to-back 8-beat packet, downstream always ready.
        track_max = 1;
        for (int i = 0; i < 8; i++) begin
            drive_beat(8'hA1 + 8'(i), i == 0, i == 7);
            tick();
        end
        idle_all(1'b1);
        repeat (12) tick();
        track_max = 0;
        check("ct_max_level", 32'(max_lvl0), 32'd1);

        // Fill with downstream stalled, simultaneous push/pop at full, then drain.
        for (int r = 0; r < 10; r++) begin
            idle_all(1'b0);
            for (int i = 0; i < 5; i++) begin
                drive_beat(8'(r * 16 + i), i == 0, i == 4);
                tick();
            end
            drive_beat(8'hEE, 1'b0, 1'b1);
            for (int k = 0; k < N; k++) out_rdy[k] = 1'b1;
            tick();
            idle_all(1'b1);
            repeat (10) tick();
        end

        // Store-forward packet with an idle cycle between beats.
        idle_all(1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_beat(8'hC0 + 8'(i), i == 0, i == 2);
            tick();
            idle_all(1'b1);
            tick();
        end
        repeat (6) tick();

        // Flush with level 3 and a simultaneous push.
        idle_all(1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_beat(8'h50 + 8'(i), i == 0, 1'b0);
            tick();
        end
        drive_beat(8'h5F, 1'b0, 1'b1);
        for (int k = 0; k < N; k++) flush[k] = 1'b1;
        tick();
        idle_all(1'b0);
        check("flush_level", 32'(level_a[0]), 32'd0);
        check("flush_vld", 32'(out_vld_a[0]), 32'd0);
        repeat (3) tick();

        // Reset in the middle of a packet.
        for (int i = 0; i < 2; i++) begin
            drive_beat(8'h70 + 8'(i), i == 0, 1'b0);
            tick();
        end
        drive_beat(8'h7F, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle_all(1'b1);
        check("rst_mid_level", 32'(level_a[1]), 32'd0);
        check("rst_mid_rdy", 32'(in_rdy_a[1]), 32'd1);
        tick();

        // Randomized traffic with a varying downstream duty cycle.
        for (int seg = 0; seg < 20; seg++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(10, 100);
            for (int c = 0; c < 100; c++) begin
                for (int k = 0; k < N; k++) begin
                    in_vld[k]   = $urandom_range(0, 9) < 7;
                    in_data[k]  = 8'($urandom_range(0, 255));
                    in_empty[k] = 2'($urandom_range(0, 3));
                    in_sop[k]   = $urandom_range(0, 3) == 0;
                    in_eop[k]   = $urandom_range(0, 3) == 0;
                    out_rdy[k]  = $urandom_range(1, 100) <= rdy_pct;
                    flush[k]    = $urandom_range(0, 49) == 0;
                end
                tick();
            end
        end
        idle_all(1'b1);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avalon_stream_buffer.md
Name: avalon_stream_buffer

Overview:
Parametrised Avalon-ST elastic buffer that replaces the fixed shift-register sampler. It has a circular storage of DEPTH entries and supports any depth of 2 or more, including non-power-of-two. It has two modes: cut-through and store-and-forward (whole-packet release). It also provides a synchronous flush and occupancy/packet-count status. It sits between any two avalon_st_if stages, for example at a packet parser input or a clock-domain-crossing FIFO output.

Parameters:
DEPTH, 4, number of payload entries; legal range 2..64; elaboration-time $fatal outside the range.
MODE, MODE_CUT_THROUGH, buffer_mode_e; MODE_STORE_FWD withholds output until a complete packet (eop stored) is present.
SUPPRESS_WARNING, 0, when 1, silences the elaboration warning issued for DEPTH > 16.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
flush  input  1  synchronous clear of all stored entries.
msg_in  avalon_st_if.slave  DATA_WIDTH+META_WIDTH+2  upstream stream (data, empty, sop, eop, vld, rdy).
msg_out  avalon_st_if.master  same  downstream stream.
level  output  $clog2(DEPTH+1)  number of stored entries.
pkt_count  output  $clog2(DEPTH+1)  number of stored entries with eop=1.
full  output  1  level == DEPTH.
empty  output  1  level == 0.

Behaviour:
- Elaboration: $fatal if the msg_in and msg_out DATA_WIDTH differ.
- Reset (rst_n low at the clk edge): wr_ptr=0, rd_ptr=0, level=0, pkt_count=0. After that edge: empty=1, full=0, msg_out.vld=0, msg_in.rdy=1. Storage contents are not reset. A reset mid-packet discards all content.
- in_tran = msg_in.vld & msg_in.rdy; out_tran = msg_out.vld & msg_out.rdy.
- msg_in.rdy = ~full & ~flush. It is registered-state only, with no combinational path from msg_out.rdy, so a push is refused at full even if a pop happens in the same cycle.
- Push: mem[wr_ptr] <= payload_in; wr_ptr advances, wrapping from DEPTH-1 to 0.
- Pop: msg_out payload = mem[rd_ptr], read combinationally from registers; rd_ptr advances with the same wrap rule.
- Latency: a beat accepted in cycle N appears on msg_out at N+1 (cut-through, buffer otherwise empty). Throughput is 1 beat/cycle whenever neither side stalls.
- level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- pkt_count: +1 on a push with eop, -1 on a pop with eop; both in the same cycle nets to zero.
- msg_out.vld:
  - MODE_CUT_THROUGH: ~empty.
  - MODE_STORE_FWD: ~empty & (pkt_count != 0 | full).
  - The full override prevents deadlock on packets longer than DEPTH; such packets degrade to cut-through.
- Once msg_out.vld is asserted, payload and vld hold until out_tran or flush. Avalon no-retract rule.
- Flush, at the clk edge: ptrs, level and pkt_count go to 0. Flush takes priority over a simultaneous push or pop; neither takes effect. msg_out.vld is forced to 0 in the flush cycle. rst_n has priority over flush.
- sop/eop framing errors are not checked; the block is payload-transparent.

Decomposition:
- avalon_pkg:
  - buffer_mode_e enum {MODE_CUT_THROUGH, MODE_STORE_FWD}.
  - Function ptr_w(depth) returning the max(1,$clog2(depth)) pointer width.
- Sub-module _wrap_ctr #(MAX): synchronous clear, enable, and wrap from MAX-1 to 0. It is instantiated twice, for wr_ptr and rd_ptr.
- level and pkt_count are kept in the top module.

Test Plan:
- Cut-through, DEPTH=4, downstream rdy=1: push beats 0xA1..0xA8 back to back -> identical sequence out, each beat 1 cycle later; level never exceeds 1.
- Fill to full, DEPTH=3 (non-power-of-two), downstream rdy=0: push 5 beats -> 3 accepted, full=1, msg_in.rdy=0. Release rdy -> 3 beats out in order; wr_ptr/rd_ptr wrap 2->0 correctly across 10 repetitions.
- At full, vld=1 and rdy=1 on both sides in the same cycle -> pop only, level 3->2, msg_in.rdy=1 the next cycle.
- Store-fwd, DEPTH=8: push a 3-beat packet with 1 idle cycle per beat -> msg_out.vld stays 0 until the cycle after the eop beat is stored, then 3 beats out with sop/eop intact; pkt_count goes 1->0.
- Store-fwd, DEPTH=4, 6-beat packet -> vld asserts when level reaches 4 and all 6 beats emerge in order, with no deadlock.
- Flush asserted with level=3 and a simultaneous push -> the next cycle has level=0, empty=1, vld=0, and the pushed beat is dropped. Reset asserted mid-packet -> same result, with msg_in.rdy=1 after the edge.
